// File: rtl/rob_pkg.sv
// Shared ROB fill types: payload record and output-register occupancy state.
package rob_pkg;

    localparam int ROB_IDX_W = 5;
    localparam int DATA_W    = 32;

    // One fill: target ROB entry, result data and exception flag.
    typedef struct packed {
        logic [ROB_IDX_W-1:0] idx;
        logic [DATA_W-1:0]    data;
        logic                 exc;
    } rob_fill_t;

    // Occupancy of the one-entry ROB write register.
    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

endpackage

// File: rtl/rob_fill_responder_rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr (upward, with wrap) wins.
// Also supplies the pointer value that follows a grant.
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    input  logic         en,
    output logic [N-1:0] gnt,
    output logic [W-1:0] gnt_idx,
    output logic [W-1:0] ptr_nxt
);

    int   cand;
    logic found;

    // Rotating priority search starting at ptr; one-hot grant plus its index.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        ptr_nxt = ptr;
        found   = 1'b0;
        cand    = 0;
        for (int k = 0; k < N; k++) begin
            cand = (int'(ptr) + k) % N;
            if (en && !found && req[cand]) begin
                found        = 1'b1;
                gnt[cand]    = 1'b1;
                gnt_idx      = W'(cand);
                ptr_nxt      = (cand == N - 1) ? '0 : W'(cand + 1);
            end
        end
    end

endmodule

// File: rtl/rob_fill_responder.sv
// ROB-side fill responder: arbitrates requester fills round-robin and drives
// the single ROB write port through a one-entry output register.
module rob_fill_responder #(
    parameter int NUM_REQ   = 4,
    parameter int ROB_IDX_W = rob_pkg::ROB_IDX_W,
    parameter int DATA_W    = rob_pkg::DATA_W,
    parameter int CNT_W     = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*ROB_IDX_W-1:0] req_rob_idx,
    input  logic [NUM_REQ*DATA_W-1:0]    req_data,
    input  logic [NUM_REQ-1:0]           req_exc,
    output logic [NUM_REQ-1:0]           req_ack,
    output logic                         rob_wr_en,
    output logic [ROB_IDX_W-1:0]         rob_wr_idx,
    output logic [DATA_W-1:0]            rob_wr_data,
    output logic                         rob_wr_exc,
    input  logic                         rob_wr_ready,
    output logic [CNT_W-1:0]             fill_cnt
);

    import rob_pkg::*;

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   ptr_nxt;
    logic [PTR_W-1:0]   gnt_idx;
    logic [NUM_REQ-1:0] gnt;
    logic               can_accept;
    logic               arb_en;
    logic               grant;
    int                 sel;

    rob_fill_t          fill_p0;
    rob_fill_t          out_p1;
    out_state_t         state_p1;
    out_state_t         state_nxt;
    logic [CNT_W-1:0]   cnt_p1;

    // Stage p0: arbitration and payload select. Reset also blocks acks so a
    // reset cycle never hands out a fill that would then be dropped.
    assign can_accept = (state_p1 == OUT_EMPTY) | rob_wr_ready;
    assign arb_en     = can_accept & ~flush & ~rst;

    rr_arbiter #(.N(NUM_REQ), .W(PTR_W)) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .en      (arb_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .ptr_nxt (ptr_nxt)
    );

    assign grant   = |gnt;
    assign req_ack = gnt;

    // Mux the winning requester's payload onto the output register input.
    always_comb begin
        sel          = int'(gnt_idx);
        fill_p0      = '0;
        fill_p0.idx  = req_rob_idx[sel*ROB_IDX_W +: ROB_IDX_W];
        fill_p0.data = req_data[sel*DATA_W +: DATA_W];
        fill_p0.exc  = req_exc[sel];
    end

    // Stage p1: output register occupancy state.
    always_ff @(posedge clk) begin
        if (rst) state_p1 <= OUT_EMPTY;
        else     state_p1 <= state_nxt;
    end

    // Flush empties the register even if the ROB took the write this cycle;
    // a grant refills it, replacing any entry draining in the same cycle.
    always_comb begin
        state_nxt = state_p1;
        if (flush)                                 state_nxt = OUT_EMPTY;
        else if (grant)                            state_nxt = OUT_FULL;
        else if (state_p1 == OUT_FULL && rob_wr_ready) state_nxt = OUT_EMPTY;
    end

    // Write strobe follows occupancy.
    always_comb begin
        rob_wr_en = (state_p1 == OUT_FULL);
    end

    // Output payload register: loads only on a grant, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst)        out_p1 <= '0;
        else if (grant) out_p1 <= fill_p0;
    end

    // Priority pointer and accepted-fill counter advance once per grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
            cnt_p1 <= '0;
        end else if (grant) begin
            rr_ptr <= ptr_nxt;
            cnt_p1 <= cnt_p1 + 1'b1;
        end
    end

    assign rob_wr_idx  = out_p1.idx;
    assign rob_wr_data = out_p1.data;
    assign rob_wr_exc  = out_p1.exc;
    assign fill_cnt    = cnt_p1;

endmodule

// File: tb/tb_rob_fill_responder.sv
// Bench for rob_fill_responder: fixed vector table, hand sequences for reset
// and counter wrap, and randomized traffic against a behavioural model.
module tb_rob_fill_responder;

    localparam int N  = 4;
    localparam int IW = 5;
    localparam int DW = 32;
    localparam int CW = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic [N-1:0]    req_valid;
    logic [N*IW-1:0] req_rob_idx;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_exc;
    logic [N-1:0]    req_ack;
    logic            rob_wr_en;
    logic [IW-1:0]   rob_wr_idx;
    logic [DW-1:0]   rob_wr_data;
    logic            rob_wr_exc;
    logic            rob_wr_ready;
    logic [CW-1:0]   fill_cnt;

    always #5 clk = ~clk;

    rob_fill_responder #(.NUM_REQ(N), .ROB_IDX_W(IW), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .req_valid    (req_valid),
        .req_rob_idx  (req_rob_idx),
        .req_data     (req_data),
        .req_exc      (req_exc),
        .req_ack      (req_ack),
        .rob_wr_en    (rob_wr_en),
        .rob_wr_idx   (rob_wr_idx),
        .rob_wr_data  (rob_wr_data),
        .rob_wr_exc   (rob_wr_exc),
        .rob_wr_ready (rob_wr_ready),
        .fill_cnt     (fill_cnt)
    );

    // Requester payloads (held by the bench until acked).
    logic [IW-1:0] p_idx  [N];
    logic [DW-1:0] p_data [N];
    logic          p_exc  [N];

    // Behavioural model of the responder.
    bit            m_full;
    logic [IW-1:0] m_idx;
    logic [DW-1:0] m_data;
    logic          m_exc;
    int            m_ptr;
    int            m_cnt;

    int            n_pass;
    int            n_tot;
    logic [N-1:0]  last_ack;
    int            last_g;

    typedef struct {
        logic [N-1:0] v;
        logic         rdy;
        logic         fl;
        logic [N-1:0] ack;
        int           wr;   // requester whose fill is on the write port, -1 if none
        int           cnt;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // One clock: drive at negedge, sample ack before the edge, outputs after it.
    task automatic cycle(input logic [N-1:0] v, input logic rdy, input logic fl,
                         input logic r, input bit chk_model);
        int g;
        @(negedge clk);
        req_valid    = v;
        rob_wr_ready = rdy;
        flush        = fl;
        rst          = r;
        for (int i = 0; i < N; i++) begin
            req_rob_idx[i*IW +: IW] = p_idx[i];
            req_data[i*DW +: DW]    = p_data[i];
            req_exc[i]              = p_exc[i];
        end
        #1;
        g = -1;
        if (!r && !fl && (!m_full || rdy)) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (g < 0 && v[c]) g = c;
            end
        end
        last_g   = g;
        last_ack = req_ack;
        if (chk_model) chk("ack", 64'(req_ack), (g < 0) ? 64'd0 : (64'd1 << g));
        if (r) begin
            m_full = 0; m_idx = '0; m_data = '0; m_exc = 1'b0; m_ptr = 0; m_cnt = 0;
        end else if (fl) begin
            m_full = 0;
        end else if (g >= 0) begin
            m_full = 1;
            m_idx  = p_idx[g];
            m_data = p_data[g];
            m_exc  = p_exc[g];
            m_ptr  = (g + 1) % N;
            m_cnt  = (m_cnt + 1) % (1 << CW);
        end else if (m_full && rdy) begin
            m_full = 0;
        end
        @(posedge clk);
        #1;
        if (chk_model) begin
            chk("wr_en", 64'(rob_wr_en), 64'(m_full));
            chk("fill_cnt", 64'(fill_cnt), 64'(m_cnt));
            if (m_full || r) begin
                chk("wr_idx", 64'(rob_wr_idx), 64'(m_idx));
                chk("wr_data", 64'(rob_wr_data), 64'(m_data));
                chk("wr_exc", 64'(rob_wr_exc), 64'(m_exc));
            end
        end
    endtask

    initial begin
        bit pend [N];
        logic [N-1:0] v;

        n_pass = 0; n_tot = 0;
        rst = 1'b1; flush = 1'b0; rob_wr_ready = 1'b1;
        req_valid = '0; req_rob_idx = '0; req_data = '0; req_exc = '0;
        for (int i = 0; i < N; i++) begin
            p_idx[i]  = IW'(8 + i);
            p_data[i] = 32'h1000 + i;
            p_exc[i]  = (i == 3);
        end
        p_idx[0]  = 5'd3;
        p_data[0] = 32'hDEAD;

        // Reset state.
        cycle('0, 1'b1, 1'b0, 1'b1, 0);
        cycle('0, 1'b1, 1'b0, 1'b1, 0);
        chk("rst_ack", 64'(last_ack), 64'd0);
        chk("rst_wr_en", 64'(rob_wr_en), 64'd0);
        chk("rst_wr_idx", 64'(rob_wr_idx), 64'd0);
        chk("rst_wr_data", 64'(rob_wr_data), 64'd0);
        chk("rst_wr_exc", 64'(rob_wr_exc), 64'd0);
        chk("rst_fill_cnt", 64'(fill_cnt), 64'd0);

        // v, rdy, flush, expected ack, requester on write port, expected count
        tbl[0]  = '{4'b0001, 1'b1, 1'b0, 4'b0001,  0, 1};
        tbl[1]  = '{4'b1111, 1'b1, 1'b0, 4'b0010,  1, 2};
        tbl[2]  = '{4'b1111, 1'b1, 1'b0, 4'b0100,  2, 3};
        tbl[3]  = '{4'b1111, 1'b1, 1'b0, 4'b1000,  3, 4};
        tbl[4]  = '{4'b1111, 1'b1, 1'b0, 4'b0001,  0, 5};
        tbl[5]  = '{4'b0100, 1'b0, 1'b0, 4'b0000,  0, 5};
        tbl[6]  = '{4'b0100, 1'b0, 1'b0, 4'b0000,  0, 5};
        tbl[7]  = '{4'b0100, 1'b0, 1'b0, 4'b0000,  0, 5};
        tbl[8]  = '{4'b0100, 1'b1, 1'b0, 4'b0100,  2, 6};
        tbl[9]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, -1, 6};
        tbl[10] = '{4'b0010, 1'b1, 1'b1, 4'b0000, -1, 6};
        tbl[11] = '{4'b0010, 1'b1, 1'b0, 4'b0010,  1, 7};
        tbl[12] = '{4'b1001, 1'b1, 1'b1, 4'b0000, -1, 7};
        tbl[13] = '{4'b1001, 1'b1, 1'b0, 4'b1000,  3, 8};

        for (int i = 0; i < 14; i++) begin
            cycle(tbl[i].v, tbl[i].rdy, tbl[i].fl, 1'b0, 0);
            chk($sformatf("vec%0d_ack", i), 64'(last_ack), 64'(tbl[i].ack));
            chk($sformatf("vec%0d_wr_en", i), 64'(rob_wr_en), 64'(tbl[i].wr >= 0));
            if (tbl[i].wr >= 0) begin
                chk($sformatf("vec%0d_wr_idx", i), 64'(rob_wr_idx), 64'(p_idx[tbl[i].wr]));
                chk($sformatf("vec%0d_wr_data", i), 64'(rob_wr_data), 64'(p_data[tbl[i].wr]));
                chk($sformatf("vec%0d_wr_exc", i), 64'(rob_wr_exc), 64'(p_exc[tbl[i].wr]));
            end
            chk($sformatf("vec%0d_cnt", i), 64'(fill_cnt), 64'(tbl[i].cnt));
        end

        // Reset while FULL with requesters 0 and 2 pending.
        cycle(4'b0101, 1'b0, 1'b0, 1'b0, 1);
        cycle(4'b0101, 1'b0, 1'b0, 1'b1, 1);
        chk("midrst_ack", 64'(last_ack), 64'd0);
        chk("midrst_wr_en", 64'(rob_wr_en), 64'd0);
        chk("midrst_wr_data", 64'(rob_wr_data), 64'd0);
        chk("midrst_cnt", 64'(fill_cnt), 64'd0);
        cycle(4'b0101, 1'b1, 1'b0, 1'b0, 1);
        chk("postrst_first_ack", 64'(last_ack), 64'b0001);
        cycle(4'b0100, 1'b1, 1'b0, 1'b0, 1);
        chk("postrst_second_ack", 64'(last_ack), 64'b0100);

        // Randomized traffic with withdrawals, back-pressure, flushes and resets.
        for (int i = 0; i < N; i++) pend[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i]) begin
                    if ($urandom_range(1, 0) == 1) begin
                        pend[i]   = 1;
                        p_idx[i]  = IW'($urandom);
                        p_data[i] = $urandom;
                        p_exc[i]  = ($urandom_range(3, 0) == 0);
                    end
                end else if ($urandom_range(15, 0) == 0) begin
                    pend[i] = 0;
                end
            end
            for (int i = 0; i < N; i++) v[i] = pend[i];
            cycle(v, ($urandom_range(3, 0) != 0), ($urandom_range(15, 0) == 0),
                  ($urandom_range(199, 0) == 0), 1);
            if (last_g >= 0) pend[last_g] = 0;
        end

        // Counter wrap, then an exception fill.
        cycle('0, 1'b1, 1'b0, 1'b1, 1);
        p_idx[0] = 5'd3; p_data[0] = 32'hDEAD; p_exc[0] = 1'b0;
        while (m_cnt != (1 << CW) - 1) cycle(4'b0001, 1'b1, 1'b0, 1'b0, 0);
        chk("cnt_max", 64'(fill_cnt), 64'hFFFF);
        p_idx[3] = 5'd7; p_data[3] = 32'hBEEF; p_exc[3] = 1'b1;
        cycle(4'b1000, 1'b1, 1'b0, 1'b0, 1);
        chk("cnt_wrap", 64'(fill_cnt), 64'd0);
        chk("exc_fill", 64'(rob_wr_exc), 64'd1);
        chk("exc_fill_ack", 64'(last_ack), 64'b1000);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
